// File: rtl/seq_uart_pkg.sv
// Shared types and constants for the sequence-value UART transmitter.
// A frame is one start bit, eight data bits (LSB first) and one stop bit.
package seq_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous byte FIFO with an explicit occupancy count.
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never makes room for a push while full.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_uart_tx.sv
// Buffers strobed sequence values and sends each one as an 8N1 UART frame.
// tx is registered and idles high; a sticky overflow flag records dropped bytes.
module seq_uart_tx
  import seq_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  input  logic                        clr_ovf,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output tx_state_t                   tx_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  // Input handshake: a byte is taken on an edge where in_valid && in_ready;
  // in_valid with !in_ready drops the byte and sets overflow. in_ready does
  // not depend on in_valid.
  tx_state_t      state, state_n;
  logic [BW-1:0]  baud, baud_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shift, shift_n;
  logic           tx_q, tx_n;
  logic           pop;
  logic [7:0]     head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           baud_last;
  logic           drop;

  seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign drop      = in_valid && fifo_full;
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);
  assign tx        = tx_q;
  assign tx_state  = state;

  always_comb begin
    state_n   = state;
    baud_n    = baud + BW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx_q;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n    = '0;
        bit_idx_n = '0;
        tx_n      = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud_last) begin
          state_n   = DATA;
          baud_n    = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            // The next bit to send is always shift[1] before the shift.
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_last) begin
          state_n = IDLE;
          baud_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/seq_uart_tx.md
# seq_uart_tx

Downstream serial stage for the integer-sequence generator top. It accepts the 8-bit sequence value selected on `uo_out` whenever a sample strobe is asserted and buffers it in a small FIFO. It then transmits each byte as an 8N1 UART frame on one bidirectional pin (`uio_out[0]`, with `uio_oe = 8'h01` at the top), so a host can log sequence values without sampling all eight output pins.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, default 8: byte-buffer entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample strobe; the byte is offered this cycle.
- `in_data`  in  8  sequence value to buffer.
- `in_ready`  out  1  FIFO not full.
- `clr_ovf`  in  1  clears the sticky `overflow` flag.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  transmitter not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag; set when a byte is dropped.

## Operation

- **Push:** occurs at a clock edge when `in_valid && in_ready`.
- **Drop:** when `in_valid && !in_ready`, the byte is discarded and `overflow` is set.
- **`in_ready`:** equals `fifo_count != FIFO_DEPTH`, derived from registered state only. A pop in the same cycle does not free space for a push while full.
- **Push and pop in the same cycle:** `fifo_count` is unchanged.
- **`clr_ovf`:** clears `overflow` at the next edge. If a drop occurs in the same cycle, set wins.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START, with `tx` = 0 from that edge. Otherwise stay in IDLE with `tx` = 1.
  - START: lasts `CLKS_PER_BIT` cycles, `tx` = 0, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. Uses a bit index 0..7, then goes to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Mandatory IDLE cycle:** IDLE lasts at least 1 cycle between frames, so the frame-to-frame period is `10*CLKS_PER_BIT + 1` cycles.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and wraps; it resets to 0 on every state entry.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. Occupancy is tracked with a count, never by pointer comparison alone.
- **`busy`:** equals `state != IDLE`.

## Timing

- **Reset values:** `tx` = 1, `busy` = 0, `fifo_count` = 0, `in_ready` = 1, `overflow` = 0, state = IDLE, pointers = 0. Reset takes effect asynchronously on assertion and releases on the next edge.
- **Reset mid-frame:** `tx` returns high immediately, the FIFO is emptied, and the partially sent byte is lost.
- **Latency:** for a push at edge k into an empty FIFO with the FSM in IDLE:
  - the pop occurs at edge k+1, and `tx` falls at edge k+1;
  - the stop bit ends at edge k+1+`10*CLKS_PER_BIT`, where `busy` falls.
- **Counter updates:** `fifo_count` and `in_ready` update at the edge following the push/pop.

## Structure

- **Package `seq_uart_pkg`:** holds the `tx_state_t` enum (IDLE, START, DATA, STOP) and the constants `FRAME_BITS` = 10 and `DATA_BITS` = 8.
- **Sub-module `seq_fifo`:** synchronous FIFO, parameterised by `FIFO_DEPTH`, with push/pop/count/full/empty. The top contains the FSM, baud counter, shift register and overflow logic.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 8.
- **Reset:** assert `reset` mid-simulation -> `tx` = 1, `busy` = 0, `fifo_count` = 0, `in_ready` = 1, `overflow` = 0, all within the same cycle.
- **Single frame:** push 0xA5 at edge k -> `tx` low over edges k+1..k+5, then data bits 1,0,1,0,0,1,0,1 each held 4 cycles, then stop bit high 4 cycles; `busy` falls at edge k+41.
- **Overflow:** assert `in_valid` for 10 consecutive cycles with data 0x10..0x19 -> 0x10 popped at edge 1; `fifo_count` reaches 8 after edge 8; `in_ready` = 0; 0x19 dropped; `overflow` = 1; bytes 0x10..0x18 serialised in order.
- **Back-to-back frames:** push 0x00 and 0xFF on consecutive cycles -> the second start bit begins exactly 41 cycles after the first, with exactly one high IDLE cycle after the stop bit.
- **Reset during DATA:** assert `reset` during bit 3 of a frame with 3 bytes queued -> `tx` = 1 immediately and `fifo_count` = 0. After release, no frame is sent until a new push.
- **Set-wins on overflow clear:** with the FIFO full, assert `clr_ovf` and `in_valid` in the same cycle -> `overflow` remains 1. Then assert `clr_ovf` alone -> `overflow` = 0 at the next edge.
